alu_op_decoder: RTL
===================

# alu_op_decoder

Registered decode stage that turns a 32-bit RV32I instruction into the 4-bit operation code and operand selects consumed by the `ALU` execute unit. It sits between instruction fetch and execute. Instructions enter over a valid/ready handshake and leave one cycle later, together with decoded fields and the generated immediate, through a single-entry output register that supports stall and flush.

## Interface
Parameters:
- `XLEN`, 32, datapath and instruction width. Only 32 is supported.

Ports:
- `clk`, in, 1. Single clock. All state updates on the rising edge.
- `rst_n`, in, 1. Asynchronous, active-low reset.
- `in_valid`, in, 1. Fetch is presenting an instruction.
- `in_ready`, out, 1. Stage can accept an instruction this cycle.
- `in_instr`, in, 32. Raw instruction word.
- `in_pc`, in, 32. PC of `in_instr`.
- `flush`, in, 1. Discard the held instruction and any instruction offered this cycle.
- `out_valid`, out, 1. Decoded bundle is valid.
- `out_ready`, in, 1. Execute accepts the bundle.
- `alu_ctrl`, out, 4. ALU operation code.
- `a_sel_pc`, out, 1. Operand A is the PC. When 0, operand A is rs1.
- `b_sel_imm`, out, 1. Operand B is `imm`. When 0, operand B is rs2.
- `imm`, out, 32. Sign-extended immediate.
- `rs1`, `rs2`, `rd`, out, 5 each. Register indices.
- `reg_we`, `mem_re`, `mem_we`, `branch`, `jump`, out, 1 each. Control flags.
- `illegal`, out, 1. Unrecognised opcode or funct field.
- `out_pc`, out, 32. PC carried with the instruction.

## Operation
- ALU op codes: `0000` PASS_B, `0001` ADD, `0010` SUB, `0011` AND, `0100` OR, `0101` XOR, `0110` SLL, `0111` SRL, `1000` SRA, `1001` SLTU, `1010` SLT.
- OP (`0110011`) and OP-IMM (`0010011`):
  - funct3/funct7 select the op. funct7[5] selects SUB for R-type and SRA for shifts.
  - OP-IMM sets `b_sel_imm=1`.
  - For shifts, `imm` = zero-extended shamt[4:0].
  - Any other funct7 is `illegal`.
- LUI: PASS_B, `b_sel_imm=1`, `imm`={instr[31:12],12'b0}.
- AUIPC: ADD, `a_sel_pc=1`, `b_sel_imm=1`.
- LOAD / STORE: ADD, `b_sel_imm=1`. Set `mem_re` for loads and `mem_we` for stores. Stores have `reg_we=0`.
- BRANCH: `branch=1`, `reg_we=0`, `b_sel_imm=0`. Op by funct3: BEQ/BNE → SUB, BLT/BGE → SLT, BLTU/BGEU → SLTU. funct3 010/011 is `illegal`.
- JAL / JALR: ADD, `jump=1`, `reg_we=1`. JAL sets `a_sel_pc=1`. JALR uses rs1 with `b_sel_imm=1`.
- Immediates are generated per I/S/B/U/J format, sign-extended from instr[31].
- Illegal instructions:
  - The bundle is still emitted with `illegal=1` and `alu_ctrl=0000`.
  - `reg_we`, `mem_re`, `mem_we`, `branch` and `jump` are all 0.
- `rd` writes to x0 pass through unchanged. Execute and writeback ignore them.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N is visible on the outputs after edge N.
- `in_ready = !out_valid || out_ready`. This path is combinational, with no bubble when the stage is full and drained in the same cycle.
- Load when `in_valid && in_ready && !flush`. The output register captures the decoded bundle and `out_valid` goes to 1.
- If `out_ready` is high and no load happens, `out_valid` goes to 0.
- While `out_valid && !out_ready`, every output stays stable. `in_ready=0`.
- `flush`:
  - At the next edge `out_valid=0`.
  - An instruction offered in the same cycle is dropped, even if `in_ready=1`.
  - Flush takes priority over load and hold.
- Reset (async, `rst_n=0`):
  - Immediately `out_valid=0`.
  - All bundle fields are 0: `alu_ctrl=0000`, `imm=0`, indices 0, all flags 0, `out_pc=0`.
  - A mid-stream reset discards the held instruction.
- Deassertion of `rst_n` is synchronised externally. The stage accepts on the first edge after release.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU op-code constants;
  - the RV32I opcode constants;
  - a packed `decode_bundle_t` struct containing every output field except `out_valid` and `out_pc`.
- The `ALU` block is switched to the same package constants.
- Sub-module `alu_op_decode_comb`: purely combinational, instruction → `decode_bundle_t`.
- The top level holds only the handshake logic and the output register.

## Test plan
- `add x3,x1,x2`, 0x002081B3, `out_ready=1`: one cycle later `alu_ctrl=0001`, `rd=3`, `rs1=1`, `rs2=2`, `b_sel_imm=0`, `reg_we=1`.
- `srai x5,x6,3`, 0x40335293: `alu_ctrl=1000`, `imm=0x00000003`, `b_sel_imm=1`. Then `sub x1,x2,x3`, 0x403100B3: `alu_ctrl=0010`.
- `lui x1,0x12345`, 0x123450B7: `alu_ctrl=0000`, `imm=0x12345000`. Follow with a stream of 4 instructions while `out_ready` is held at 0 for 3 cycles: outputs stay frozen and `in_ready=0`. After release, all 4 instructions appear in order with no loss or duplication.
- 0xFFFFFFFF: `illegal=1`, `alu_ctrl=0000`, all write and memory flags 0.
- `flush` while holding a stalled bundle, with a new valid instruction offered in the same cycle: `out_valid=0` next cycle and the offered instruction never appears.
- `rst_n` pulsed low mid-stream, asynchronously between edges: `out_valid` drops immediately and all fields read 0. The first instruction after release decodes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcodes and the decoded bundle used by the
// decode stage and the ALU execute unit.
package alu_pkg;

    localparam logic [3:0] ALU_PASS_B = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0001;
    localparam logic [3:0] ALU_SUB    = 4'b0010;
    localparam logic [3:0] ALU_AND    = 4'b0011;
    localparam logic [3:0] ALU_OR     = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SLL    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] ALU_SRA    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_SLT    = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic        a_sel_pc;
        logic        b_sel_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        illegal;
    } decode_bundle_t;

    // Shared by OP and OP-IMM; alt is funct7[5] where it is meaningful.
    function automatic logic [3:0] arith_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// Combinational RV32I decode: instruction word to ALU op, operand selects,
// immediate, register indices and control flags.
module alu_op_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0]    instr,
    output decode_bundle_t dec
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec     = '0;
        bad     = 1'b0;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec.alu_ctrl = arith_op(funct3, funct7[5]);
                dec.reg_we   = 1'b1;
                bad = !(funct7 == 7'b0000000 ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                // instr[30] is an immediate bit except on right shifts
                dec.alu_ctrl  = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
                dec.b_sel_imm = 1'b1;
                dec.reg_we    = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.imm = {27'b0, instr[24:20]};
                    bad = !(funct7 == 7'b0000000 ||
                            (funct3 == 3'b101 && funct7 == 7'b0100000));
                end else begin
                    dec.imm = imm_i;
                end
            end
            OPC_LUI: begin
                dec.alu_ctrl  = ALU_PASS_B;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_u;
                dec.reg_we    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_ctrl  = ALU_ADD;
                dec.a_sel_pc  = 1'b1;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_u;
                dec.reg_we    = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_ctrl  = ALU_ADD;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_i;
                dec.reg_we    = 1'b1;
                dec.mem_re    = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_ctrl  = ALU_ADD;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_s;
                dec.mem_we    = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                case (funct3)
                    3'b000, 3'b001: dec.alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: dec.alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: dec.alu_ctrl = ALU_SLTU;
                    default:        bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec.alu_ctrl  = ALU_ADD;
                dec.a_sel_pc  = 1'b1;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_j;
                dec.reg_we    = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_ctrl  = ALU_ADD;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_i;
                dec.reg_we    = 1'b1;
                dec.jump      = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // Illegal bundles keep the raw register indices but no side effects
        if (bad) begin
            dec.alu_ctrl  = ALU_PASS_B;
            dec.a_sel_pc  = 1'b0;
            dec.b_sel_imm = 1'b0;
            dec.imm       = '0;
            dec.reg_we    = 1'b0;
            dec.mem_re    = 1'b0;
            dec.mem_we    = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end
        dec.illegal = bad;
    end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered decode stage between fetch and execute: valid/ready input,
// single-entry output register with stall and flush.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic            a_sel_pc,
    output logic            b_sel_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            branch,
    output logic            jump,
    output logic            illegal,
    output logic [XLEN-1:0] out_pc
);

    decode_bundle_t  dec_next;
    decode_bundle_t  dec_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            load;

    alu_op_decode_comb u_decode (
        .instr (in_instr),
        .dec   (dec_next)
    );

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            dec_q   <= dec_next;
            pc_q    <= in_pc;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign alu_ctrl  = dec_q.alu_ctrl;
    assign a_sel_pc  = dec_q.a_sel_pc;
    assign b_sel_imm = dec_q.b_sel_imm;
    assign imm       = dec_q.imm;
    assign rs1       = dec_q.rs1;
    assign rs2       = dec_q.rs2;
    assign rd        = dec_q.rd;
    assign reg_we    = dec_q.reg_we;
    assign mem_re    = dec_q.mem_re;
    assign mem_we    = dec_q.mem_we;
    assign branch    = dec_q.branch;
    assign jump      = dec_q.jump;
    assign illegal   = dec_q.illegal;
    assign out_pc    = pc_q;

endmodule
